// File: rtl/spi_pkg.sv
// Shared SPI constants: frame geometry, controller FSM encodings, peripheral register map.
package spi_pkg;
   localparam int SPI_FRAME_W = 16;
   localparam int SPI_ADDR_W  = 7;
   localparam int SPI_DATA_W  = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

   typedef struct packed {
      logic                  rw;
      logic [SPI_ADDR_W-1:0] addr;
      logic [SPI_DATA_W-1:0] data;
   } spi_frame_t;

   function automatic spi_frame_t make_frame(input logic rw, input logic [SPI_ADDR_W-1:0] addr,
                                             input logic [SPI_DATA_W-1:0] data);
      spi_frame_t f;
      f.rw   = rw;
      f.addr = addr;
      f.data = data;
      return f;
   endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled cycles; rise/fall strobe the cycle before the edge.
module spi_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic sclk,
   output logic sclk_rise,
   output logic sclk_fall
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic          tc;

   assign tc = (div_q == DW'(CLK_DIV - 1));

   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      if (clr) begin
         div_d  = '0;
         sclk_d = 1'b0;
      end else if (en) begin
         if (tc) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk      = sclk_q;
   assign sclk_rise = en & ~clr & tc & ~sclk_q;
   assign sclk_fall = en & ~clr & tc & sclk_q;
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller, 16-bit frames MSB first.
// Define SPI_CTRL_READBACK_EN to add CIPO capture of frame bits 7..0 into rsp_data.
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [SPI_ADDR_W-1:0] req_addr,
   input  logic [SPI_DATA_W-1:0] req_data,
   output logic                  SCLK,
   output logic                  COPI,
   output logic                  nCS,
   output logic                  busy,
   output logic                  done
`ifdef SPI_CTRL_READBACK_EN
   ,input  logic                  CIPO
   ,output logic [SPI_DATA_W-1:0] rsp_data
`endif
);
   logic [2:0]             state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
   logic                   ncs_q, ncs_d;
   logic                   done_q, done_d;
   logic                   sclk_rise, sclk_fall;
   logic                   in_shift;

   assign in_shift = (state_q == ST_SHIFT);

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (in_shift),
      .clr       (~in_shift),
      .sclk      (SCLK),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      ncs_d     = ncs_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            shreg_d   = make_frame(req_write, req_addr, req_data);
            ncs_d     = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = '0;
            state_d   = ST_SETUP;
         end
         ST_SETUP: if (cnt_q == 8'(CS_SETUP - 1)) begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end else cnt_d = cnt_q + 8'd1;
         // COPI is shreg_q[15]; advancing on the falling strobe keeps it stable around each rise.
         ST_SHIFT: if (sclk_fall) begin
            if (bit_cnt_q == 4'd15) begin
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               shreg_d   = {shreg_q[SPI_FRAME_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_HOLD: if (cnt_q == 8'(CS_HOLD - 1)) begin
            ncs_d   = 1'b1;
            shreg_d = '0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_GAP;
         end else cnt_d = cnt_q + 8'd1;
         ST_GAP: if (cnt_q == 8'(CS_IDLE - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end else cnt_d = cnt_q + 8'd1;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         ncs_q     <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         ncs_q     <= ncs_d;
         done_q    <= done_d;
      end
   end

`ifdef SPI_CTRL_READBACK_EN
   logic [SPI_DATA_W-1:0] rx_q, rx_d, rsp_q, rsp_d;

   // bit_cnt 8..15 covers the data byte of the frame.
   always_comb begin
      rx_d  = rx_q;
      rsp_d = rsp_q;
      if (sclk_rise && bit_cnt_q[3]) rx_d = {rx_q[SPI_DATA_W-2:0], CIPO};
      if (done_d) rsp_d = rx_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_q  <= '0;
         rsp_q <= '0;
      end else begin
         rx_q  <= rx_d;
         rsp_q <= rsp_d;
      end
   end

   assign rsp_data = rsp_q;
`else
   logic unused_rise;
   assign unused_rise = sclk_rise;
`endif

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign nCS       = ncs_q;
   assign COPI      = shreg_q[SPI_FRAME_W-1];
endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller with a behavioural register peripheral on the SPI pins.
module tb_spi_controller;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [6:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       req_ready, SCLK, COPI, nCS, busy, done;
`ifdef SPI_CTRL_READBACK_EN
   logic       CIPO = 1'b0;
   logic [7:0] rsp_data;
`endif

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  rsp;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors = 0;
   int         errs = 0;
   int         last_gap = 0;
   logic [7:0] regs[0:4];
   logic [7:0] cb = 8'h00;

   spi_controller #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
      .SCLK(SCLK), .COPI(COPI), .nCS(nCS), .busy(busy), .done(done)
`ifdef SPI_CTRL_READBACK_EN
      , .CIPO(CIPO), .rsp_data(rsp_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
      end
   endtask

   // Monitor: deserialises COPI on SCLK rises and checks each completed frame against the queue.
   initial begin : mon
      logic        ps, pn, had;
      int          bits, low, high;
      logic [15:0] cap;
      exp_t        e;
      ps = 1'b0; pn = 1'b1; had = 1'b0;
      bits = 0; low = 0; high = 0; cap = '0;
      for (int i = 0; i < 5; i++) regs[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) for (int i = 0; i < 5; i++) regs[i] = 8'h00;
         if (SCLK === 1'b1 && !ps) begin
            cap = {cap[14:0], COPI};
            bits++;
         end
         if (pn && nCS === 1'b0) begin
            if (had) begin
               last_gap = high;
               chk("ncs_high_gap_ge5", 32'(high >= 5), 1);
            end
            low = 0; bits = 0; cap = '0;
         end
         if (!pn && nCS === 1'b1) begin
            if (bits == 16) begin
               chk("ncs_low_cycles", low, 132);
               chk("done_at_ncs_rise", done, 1);
               if (exp_q.size() == 0) begin
                  vectors++; errs++;
                  $display("FAIL unexpected_frame: got 0x%0h, want none", cap);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame", cap, e.frame);
`ifdef SPI_CTRL_READBACK_EN
                  chk("rsp_data", rsp_data, e.rsp);
`endif
               end
               if (cap[15] && cap[14:8] <= 7'd4) regs[cap[10:8]] = cap[7:0];
               had = 1'b1;
            end else begin
               chk("abort_no_done", done, 0);
               had = 1'b0;
            end
            high = 0;
         end else if (done === 1'b1) begin
            chk("stray_done", done, 0);
         end
         if (nCS === 1'b1) high++; else low++;
`ifdef SPI_CTRL_READBACK_EN
         CIPO = (bits >= 8 && bits < 16) ? cb[3'(15 - bits)] : 1'b0;
`endif
         ps = SCLK;
         pn = nCS;
      end
   end

   task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, input bit push);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         vectors++; errs++;
         $display("FAIL req_ready_timeout: got %b, want 1", req_ready);
      end
      req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
      if (push) exp_q.push_back('{frame: {w, a, d}, rsp: cb});
      @(negedge clk);
      req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_data = ~d;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000);
      if (n >= 3000) begin
         vectors++; errs++;
         $display("FAIL idle_timeout: got busy=%b pending=%0d, want idle", busy, exp_q.size());
      end
   endtask

   initial begin : stim
      int   n, r;
      logic p;
      repeat (3) @(negedge clk);
      chk("rst_ncs", nCS, 1);
      chk("rst_sclk", SCLK, 0);
      chk("rst_copi", COPI, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);

      // single write: pwm duty 0xA5
      send(1'b1, 7'h04, 8'hA5, 1'b1);
      chk("busy_in_frame", busy, 1);
      chk("ready_in_frame", req_ready, 0);
      wait_idle();

      // request held across two frames; fields change right after the first accept
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h00; req_data = 8'hFF;
      exp_q.push_back('{frame: 16'h80FF, rsp: cb});
      @(negedge clk);
      req_addr = 7'h01; req_data = 8'h0F;
      exp_q.push_back('{frame: 16'h810F, rsp: cb});
      n = 0;
      while (req_ready !== 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("second_ready_wait", n, 136);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      chk("b2b_ncs_gap", last_gap, 5);

      // reset one cycle after the fifth SCLK rise
      send(1'b1, 7'h02, 8'h55, 1'b0);
      r = 0; n = 0; p = SCLK;
      while (r < 5 && n < 500) begin
         @(negedge clk);
         if (SCLK && !p) r++;
         p = SCLK;
         n++;
      end
      chk("fifth_rise_seen", r, 5);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ncs", nCS, 1);
      chk("midrst_sclk", SCLK, 0);
      chk("midrst_copi", COPI, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_done2", done, 0);
      repeat (6) @(negedge clk);

      // end-to-end register programming from a reset peripheral
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1'b1, 7'h01, 8'h3C, 1'b1);
      send(1'b1, 7'h04, 8'h80, 1'b1);
      wait_idle();
      chk("reg_en_out_7_0", regs[0], 8'h00);
      chk("reg_en_out_15_8", regs[1], 8'h3C);
      chk("reg_en_pwm_7_0", regs[2], 8'h00);
      chk("reg_en_pwm_15_8", regs[3], 8'h00);
      chk("reg_pwm_duty", regs[4], 8'h80);

      // read frame leaves registers alone
      send(1'b0, 7'h03, 8'h12, 1'b1);
      wait_idle();
      chk("rd_reg_en_pwm_15_8", regs[3], 8'h00);
      chk("rd_reg_en_out_15_8", regs[1], 8'h3C);
      chk("rd_reg_pwm_duty", regs[4], 8'h80);

`ifdef SPI_CTRL_READBACK_EN
      cb = 8'h5A;
      send(1'b0, 7'h02, 8'h00, 1'b1);
      wait_idle();
      cb = 8'hC3;
      send(1'b0, 7'h04, 8'h00, 1'b1);
      wait_idle();
      chk("rsp_data_hold", rsp_data, 8'hC3);
`endif

      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
